// File: rtl/skid_registered.sv
// skid_registered: fully registered valid/ready pipeline slice.
// The forward path (s_valid/s_data) and the backward path (m_ready) both
// come straight from flops. A skid register holds the one beat that can
// arrive while the downstream side stalls.
module skid_registered #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_data,
    output logic             m_ready,
    output logic             s_valid,
    output logic [WIDTH-1:0] s_data,
    input  logic             s_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             m_ready_q, m_ready_d;
    logic             s_valid_q, s_valid_d;
    logic [1:0]       count_q, count_d;

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            s_data_q    <= '0;
            skid_data_q <= '0;
            m_ready_q   <= 1'b1;
            s_valid_q   <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            s_data_q    <= s_data_d;
            skid_data_q <= skid_data_d;
            m_ready_q   <= m_ready_d;
            s_valid_q   <= s_valid_d;
            count_q     <= count_d;
        end
    end

    // Next-state and datapath load decode from the current state and handshakes.
    always_comb begin
        state_d     = state_q;
        s_data_d    = s_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            EMPTY: begin
                if (m_valid) begin
                    s_data_d = m_data;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (m_valid && s_ready) begin
                    s_data_d = m_data;
                end else if (m_valid && !s_ready) begin
                    skid_data_d = m_data;
                    state_d     = FULL;
                end else if (!m_valid && s_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // m_ready is low here, so upstream is not looked at.
                if (s_ready) begin
                    s_data_d = skid_data_q;
                    state_d  = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output flags decoded from the next state so they register with it.
    always_comb begin
        m_ready_d = 1'b1;
        s_valid_d = 1'b0;
        count_d   = 2'd0;
        unique case (state_d)
            EMPTY: begin
                m_ready_d = 1'b1;
                s_valid_d = 1'b0;
                count_d   = 2'd0;
            end
            BUSY: begin
                m_ready_d = 1'b1;
                s_valid_d = 1'b1;
                count_d   = 2'd1;
            end
            FULL: begin
                m_ready_d = 1'b0;
                s_valid_d = 1'b1;
                count_d   = 2'd2;
            end
            default: begin
                m_ready_d = 1'b1;
                s_valid_d = 1'b0;
                count_d   = 2'd0;
            end
        endcase
    end

    assign m_ready = m_ready_q;
    assign s_valid = s_valid_q;
    assign s_data  = s_data_q;
    assign count   = count_q;

endmodule

// File: doc/skid_registered.md
Name: skid_registered

Overview:
- Full-registered valid/ready pipeline slice: registers both the forward path (`s_valid`, `s_data`) and the backward path (`m_ready`).
- A 2-entry skid buffer absorbs the one beat in flight when downstream stalls.
- Dropped between pipeline stages wherever timing must be cut in both directions. Sustains 1 beat/cycle.
- Upstream side is `m_*`, downstream side is `s_*`.

Parameters:
- WIDTH, 8, data bus width in bits.

Ports:
- clk  input  1  single clock, all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- m_valid  input  1  upstream beat valid.
- m_data  input  WIDTH  upstream beat data.
- m_ready  output  1  slice can accept an upstream beat; driven directly from a flop.
- s_valid  output  1  downstream beat valid; driven directly from a flop.
- s_data  output  WIDTH  downstream beat data; driven directly from a flop.
- s_ready  input  1  downstream accepts beat.
- count  output  2  current occupancy, 0..2.

Behaviour:
- One clock, `clk`. Reset is synchronous, active-low, on `rst_n`.
- Reset values while `rst_n`=0 at a clock edge:
  - state=EMPTY, `m_ready`=1, `s_valid`=0, `s_data`=0, skid register=0, `count`=0.
  - Upstream handshakes are ignored while `rst_n`=0.
  - Reset applied mid-operation discards both buffered beats.
- Handshake definitions:
  - Upstream transfer occurs when `m_valid`&`m_ready` at a clock edge.
  - Downstream transfer occurs when `s_valid`&`s_ready` at a clock edge.
- Combinational paths: none from `s_ready` to `m_ready`, none from `m_valid`/`m_data` to `s_valid`/`s_data`. All four outputs come straight from flops.
- Storage: output register (`s_data`) and skid register (`skid_data`).
- State machine:
  - EMPTY: `count`=0, `s_valid`=0, `m_ready`=1.
  - BUSY: `count`=1, `s_valid`=1, `m_ready`=1. The beat is in the output register.
  - FULL: `count`=2, `s_valid`=1, `m_ready`=0. The head beat is in the output register, the next beat is in the skid register.
- Transitions (evaluated at each edge with `rst_n`=1):
  - EMPTY, `m_valid`=1: `s_data`<=`m_data`, go to BUSY.
  - EMPTY, `m_valid`=0: stay in EMPTY.
  - BUSY, `m_valid`=1, `s_ready`=1: `s_data`<=`m_data`, stay in BUSY (pass-through).
  - BUSY, `m_valid`=1, `s_ready`=0: `skid_data`<=`m_data`, go to FULL.
  - BUSY, `m_valid`=0, `s_ready`=1: go to EMPTY. `s_data` holds its last value.
  - BUSY, `m_valid`=0, `s_ready`=0: hold.
  - FULL, `s_ready`=1: `s_data`<=`skid_data`, go to BUSY. `m_valid` is ignored because `m_ready`=0.
  - FULL, `s_ready`=0: hold all registers.
- Output update rule: `m_ready`, `s_valid` and `count` are registered copies of the next-state decode and update on the same edge as the state.
- Latency and throughput:
  - 1 cycle from upstream transfer to `s_valid` in EMPTY.
  - Full throughput in BUSY with both sides active.
  - After `s_ready` rises in FULL, `m_ready` returns to 1 one edge later.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated.
- Stability: `s_data` never changes while `s_valid`=1 and `s_ready`=0.
- `count` matches the state encoding exactly; the value 3 is never produced.
- Simultaneous events:
  - Upstream and downstream transfers on the same edge in BUSY keep `count`=1.
  - In FULL, the downstream transfer frees exactly one entry.

Test Plan:
- Reset then pass-through: hold `rst_n`=0 for 2 clocks, then release; drive `m_data`=0x01..0x08 on consecutive cycles with `s_ready`=1 -> after reset `s_valid`=0, `m_ready`=1, `count`=0; then `s_valid` rises 1 cycle after the first beat, 8 beats appear in order, `count` stays 1, `m_ready` stays 1.
- Stall absorption: stream 0xA0, 0xA1, 0xA2 and drop `s_ready` to 0 when 0xA0 is at the output -> 0xA1 lands in skid, `count`=2, `m_ready`=0 the next cycle, 0xA2 is held upstream and `s_data` stays 0xA0.
- Drain from FULL: from the previous state raise `s_ready`=1 for 3 cycles -> outputs are 0xA0, 0xA1, 0xA2 in order, `m_ready` returns to 1 one edge after 0xA0 is accepted, `count` goes 2->1->1->0.
- Bubble upstream: `m_valid` alternates 1/0 with `s_ready`=1 and data 0x10, 0x11, 0x12 -> `s_valid` alternates, `count` toggles 1/0, no duplicate beat.
- Random backpressure: 1000 beats of an incrementing 8-bit pattern with random `m_valid` and `s_ready` -> scoreboard matches exactly; `s_data` is stable while stalled; `m_ready`=0 only when `count`=2.
- Mid-operation reset: reach FULL with 0x55/0x66, then assert `rst_n`=0 for 1 edge -> next cycle `s_valid`=0, `s_data`=0, `count`=0, `m_ready`=1; 0x55 and 0x66 never appear downstream.
